// File: rtl/md_sequencer_if.sv
// Multiply/divide unit bus: EX-stage request side and HI/LO/status return side.
interface md_sequencer_if;
   logic        md_valid;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic        stall_req;
   logic        done;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output md_valid, md_op, src_a, src_b,
      input  busy, stall_req, done, result, hi, lo
   );

   modport slave (
      input  md_valid, md_op, src_a, src_b,
      output busy, stall_req, done, result, hi, lo
   );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div unit with HI/LO registers and a fixed-latency busy counter.
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic           clk,
   input  logic           reset,
   md_sequencer_if.slave  md
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   hi_n_q, hi_n_d, lo_n_q, lo_n_d;
   logic          div0_q, div0_d;
   logic          done_q, done_d;

   logic          busy, accept;
   logic [31:0]   a, b;
   logic [63:0]   prod_s, prod_u;
   logic [31:0]   dvsr_u, uq, ur;
   logic [31:0]   mag_a, mag_b, sq_mag, sr_mag, sq, sr;

   assign a      = md.src_a;
   assign b      = md.src_b;
   assign busy   = (state_q == RUN);
   assign accept = md.md_valid & ~busy;

   always_comb begin
      prod_u = {32'd0, a} * {32'd0, b};
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      // zero divisor never commits, so a dummy divisor of 1 keeps results defined
      dvsr_u = (b == 32'd0) ? 32'd1 : b;
      uq     = a / dvsr_u;
      ur     = a % dvsr_u;
      mag_a  = a[31] ? (~a + 32'd1) : a;
      mag_b  = b[31] ? (~b + 32'd1) : b;
      if (mag_b == 32'd0) mag_b = 32'd1;
      sq_mag = mag_a / mag_b;
      sr_mag = mag_a % mag_b;
      sq     = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
      sr     = a[31] ? (~sr_mag + 32'd1) : sr_mag;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      hi_n_d  = hi_n_q;
      lo_n_d  = lo_n_q;
      div0_d  = div0_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (md.md_op)
                  3'd1: begin
                     {hi_n_d, lo_n_d} = prod_u;
                     div0_d  = 1'b0;
                     cnt_d   = CW'(MULT_CYCLES);
                     state_d = RUN;
                  end
                  3'd2: begin
                     {hi_n_d, lo_n_d} = prod_s;
                     div0_d  = 1'b0;
                     cnt_d   = CW'(MULT_CYCLES);
                     state_d = RUN;
                  end
                  3'd3: begin
                     hi_n_d  = ur;
                     lo_n_d  = uq;
                     div0_d  = (b == 32'd0);
                     cnt_d   = CW'(DIV_CYCLES);
                     state_d = RUN;
                  end
                  3'd4: begin
                     hi_n_d  = sr;
                     lo_n_d  = sq;
                     div0_d  = (b == 32'd0);
                     cnt_d   = CW'(DIV_CYCLES);
                     state_d = RUN;
                  end
                  3'd5: lo_d = a;
                  3'd6: hi_d = a;
                  3'd0, 3'd7: ;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (!div0_q) begin
                  hi_d = hi_n_q;
                  lo_d = lo_n_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         hi_n_q  <= '0;
         lo_n_q  <= '0;
         div0_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         hi_n_q  <= hi_n_d;
         lo_n_q  <= lo_n_d;
         div0_q  <= div0_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      md.result = 32'd0;
      if (md.md_valid && md.md_op == 3'd0) md.result = lo_q;
      if (md.md_valid && md.md_op == 3'd7) md.result = hi_q;
   end

   assign md.busy      = busy;
   assign md.stall_req = md.md_valid & busy;
   assign md.done      = done_q;
   assign md.hi        = hi_q;
   assign md.lo        = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, HI/LO results, stalls, reset abort.
module tb_md_sequencer;
   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   int   n;

   always #5 clk = ~clk;

   md_sequencer_if md();

   md_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .md    (md)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [2:0] op,
                         input logic [31:0] sa, input logic [31:0] sb);
      md.md_valid = v;
      md.md_op    = op;
      md.src_a    = sa;
      md.src_b    = sb;
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] sa,
                        input logic [31:0] sb);
      @(negedge clk);
      set_in(1'b1, op, sa, sb);
      chk("accept_no_stall", 32'(md.stall_req), 32'd0);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (md.busy === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1;
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 32'(md.busy), 32'd0);
      chk("rst_done", 32'(md.done), 32'd0);
      chk("rst_hi", md.hi, 32'd0);
      chk("rst_lo", md.lo, 32'd0);
      chk("rst_result", md.result, 32'd0);
      reset = 1'b0;

      // signed mult -3 * 7
      issue(3'd2, 32'hFFFF_FFFD, 32'h0000_0007);
      count_busy(n);
      chk("t1_busy_cycles", 32'(n), 32'd5);
      chk("t1_done", 32'(md.done), 32'd1);
      chk("t1_hi", md.hi, 32'hFFFF_FFFF);
      chk("t1_lo", md.lo, 32'hFFFF_FFEB);
      @(negedge clk);
      #1;
      chk("t1_done_once", 32'(md.done), 32'd0);

      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      count_busy(n);
      chk("t2_busy_cycles", 32'(n), 32'd5);
      chk("t2_hi", md.hi, 32'hFFFF_FFFE);
      chk("t2_lo", md.lo, 32'h0000_0001);

      // signed div -7 / 2 with mflo held from busy cycle 3
      issue(3'd4, 32'hFFFF_FFF9, 32'h0000_0002);
      @(negedge clk);
      @(negedge clk);
      set_in(1'b1, 3'd0, 32'd0, 32'd0);
      n = 0;
      while (md.busy === 1'b1 && n < 40) begin
         chk("t3_stall", 32'(md.stall_req), 32'd1);
         n++;
         @(negedge clk);
         #1;
      end
      chk("t3_stall_cycles", 32'(n), 32'd8);
      chk("t3_stall_drop", 32'(md.stall_req), 32'd0);
      chk("t3_result", md.result, 32'hFFFF_FFFD);
      chk("t3_hi", md.hi, 32'hFFFF_FFFF);
      chk("t3_done", 32'(md.done), 32'd1);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      chk("t3_result_idle", md.result, 32'd0);

      @(negedge clk);
      set_in(1'b1, 3'd6, 32'h0000_000A, 32'd0);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      chk("t4_mthi", md.hi, 32'h0000_000A);
      chk("t4_mthi_busy", 32'(md.busy), 32'd0);
      chk("t4_mthi_done", 32'(md.done), 32'd0);
      @(negedge clk);
      set_in(1'b1, 3'd5, 32'h0000_000B, 32'd0);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      chk("t4_mtlo", md.lo, 32'h0000_000B);
      issue(3'd3, 32'h0000_1234, 32'd0);
      count_busy(n);
      chk("t4_busy_cycles", 32'(n), 32'd10);
      chk("t4_done", 32'(md.done), 32'd1);
      chk("t4_hi", md.hi, 32'h0000_000A);
      chk("t4_lo", md.lo, 32'h0000_000B);

      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(n);
      chk("ovf_busy_cycles", 32'(n), 32'd10);
      chk("ovf_lo", md.lo, 32'h8000_0000);
      chk("ovf_hi", md.hi, 32'd0);

      // reset during the second busy cycle of a mult
      issue(3'd2, 32'd2, 32'd3);
      @(negedge clk);
      #1;
      chk("t5_busy2", 32'(md.busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      reset = 1'b0;
      chk("t5_busy", 32'(md.busy), 32'd0);
      chk("t5_hi", md.hi, 32'd0);
      chk("t5_lo", md.lo, 32'd0);
      for (int i = 0; i < 7; i++) begin
         chk("t5_no_done", 32'(md.done), 32'd0);
         @(negedge clk);
         #1;
      end
      chk("t5_lo_after", md.lo, 32'd0);

      @(negedge clk);
      set_in(1'b1, 3'd6, 32'h1234_5678, 32'd0);
      @(negedge clk);
      set_in(1'b1, 3'd7, 32'd0, 32'd0);
      chk("t6_mfhi", md.result, 32'h1234_5678);
      chk("t6_mfhi_stall", 32'(md.stall_req), 32'd0);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      issue(3'd2, 32'd2, 32'd3);
      set_in(1'b1, 3'd5, 32'h0000_0001, 32'd0);
      chk("t6_mtlo_stall", 32'(md.stall_req), 32'd1);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      chk("t6_lo_unchanged", md.lo, 32'd0);
      count_busy(n);
      chk("t6_busy_rest", 32'(n), 32'd4);
      chk("t6_hi", md.hi, 32'd0);
      chk("t6_lo", md.lo, 32'd6);
      chk("t6_done", 32'(md.done), 32'd1);
      set_in(1'b1, 3'd0, 32'd0, 32'd0);
      chk("t6_b2b_stall", 32'(md.stall_req), 32'd0);
      chk("t6_b2b_mflo", md.result, 32'd6);
      @(negedge clk);
      set_in(1'b0, 3'd0, 32'd0, 32'd0);
      chk("t6_b2b_busy", 32'(md.busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
